// File: rtl/clock_pkg.sv
// Shared types, BCD constants and BCD helper functions for bcd_alarm_clock.
// All time values are packed two-digit BCD; binary is only used transiently.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2,
    MODE_RUN_ALT   = 2'd3
  } mode_e;

  localparam logic [7:0] BCD_59         = 8'h59;
  localparam logic [7:0] BCD_23         = 8'h23;
  localparam logic [7:0] BCD_12         = 8'h12;
  localparam logic [7:0] ALARM_RST_HOUR = 8'h06;
  localparam logic [7:0] ALARM_RST_MIN  = 8'h30;

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [6:0] bcd2bin(input logic [7:0] v);
    return ({3'b000, v[7:4]} * 7'd10) + {3'b000, v[3:0]};
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] b);
    logic [6:0] tens;
    logic [6:0] ones;
    tens = b / 7'd10;
    ones = b % 7'd10;
    return {tens[3:0], ones[3:0]};
  endfunction

  // Increment with wrap to 00 after max; pure nibble arithmetic.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                   return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] hour_to12(input logic [7:0] h);
    if (h == 8'h00)       return BCD_12;
    else if (h <= BCD_12) return h;
    else                  return bin2bcd(bcd2bin(h) - 7'd12);
  endfunction

  function automatic logic hour_is_pm(input logic [7:0] h);
    return h >= BCD_12;
  endfunction

  function automatic logic [7:0] hour_to24(input logic [7:0] h12, input logic pm);
    if (h12 == BCD_12) return pm ? BCD_12 : 8'h00;
    else if (pm)       return bin2bcd(bcd2bin(h12) + 7'd12);
    else               return h12;
  endfunction

  // HH:MM + k minutes with hour and day wrap; returns {HH, MM}.
  function automatic logic [15:0] add_minutes(input logic [7:0] hh, input logic [7:0] mm,
                                              input logic [6:0] k);
    logic [10:0] t;
    t = ({4'b0000, bcd2bin(hh)} * 11'd60) + {4'b0000, bcd2bin(mm)} + {4'b0000, k};
    if (t >= 11'd1440) t = t - 11'd1440;
    return {bin2bcd(7'(t / 11'd60)), bin2bcd(7'(t % 11'd60))};
  endfunction

endpackage

// File: rtl/bcd_alarm_clock_if.sv
// Control/display bundle between the debouncers, bcd_alarm_clock and the display/piezo side.
interface bcd_alarm_clock_if #(
  parameter int unsigned NUM_ALARMS = 2
);
  localparam int unsigned AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic [1:0]            MODE;
  logic                  LOAD;
  logic                  FIELD_SEL;
  logic [AW-1:0]         ALARM_SEL;
  logic [7:0]            SW_IN;
  logic                  PM_IN;
  logic                  H24;
  logic [NUM_ALARMS-1:0] A_ENABLE;
  logic                  SNOOZE;
  logic [7:0]            HOUR;
  logic [7:0]            MIN;
  logic [7:0]            SEC;
  logic                  PM;
  logic [7:0]            AL_HOUR;
  logic [7:0]            AL_MIN;
  logic [NUM_ALARMS-1:0] RINGING;
  logic                  B;
  logic                  TICK;
  logic                  ERR;

  modport master (
    output MODE, LOAD, FIELD_SEL, ALARM_SEL, SW_IN, PM_IN, H24, A_ENABLE, SNOOZE,
    input  HOUR, MIN, SEC, PM, AL_HOUR, AL_MIN, RINGING, B, TICK, ERR
  );

  modport slave (
    input  MODE, LOAD, FIELD_SEL, ALARM_SEL, SW_IN, PM_IN, H24, A_ENABLE, SNOOZE,
    output HOUR, MIN, SEC, PM, AL_HOUR, AL_MIN, RINGING, B, TICK, ERR
  );
endinterface

// File: rtl/bcd_alarm_clock_alarm_slot.sv
// One alarm slot: stored 24-hour BCD alarm, second-00 compare and ring flag.
// With CLOCK_SNOOZE_EN defined it also holds a one-shot snooze re-ring target.
module alarm_slot #(
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_hour,
  input  logic       i_wr_min,
  input  logic [7:0] i_wr_data,
  input  logic       i_tick,
  input  logic [7:0] i_next_hour,
  input  logic [7:0] i_next_min,
  input  logic [7:0] i_next_sec,
  input  logic [7:0] i_cur_hour,
  input  logic [7:0] i_cur_min,
  input  logic       i_enable,
  input  logic       i_snooze,
  output logic [7:0] o_hour,
  output logic [7:0] o_min,
  output logic       o_ringing
);
  import clock_pkg::*;

  logic [7:0] r_hour;
  logic [7:0] r_min;
  logic       r_ringing;
  logic       w_at_min;
  logic       w_hit;

  assign w_at_min = i_tick && (i_next_sec == 8'h00);

`ifdef CLOCK_SNOOZE_EN
  logic        r_snz_valid;
  logic [7:0]  r_snz_hour;
  logic [7:0]  r_snz_min;
  logic [15:0] w_snz_target;
  logic        w_snz_hit;

  assign w_snz_target = add_minutes(i_cur_hour, i_cur_min, 7'(SNOOZE_MIN));
  assign w_snz_hit    = r_snz_valid && (i_next_hour == r_snz_hour) && (i_next_min == r_snz_min);
  assign w_hit        = w_at_min && (((i_next_hour == r_hour) && (i_next_min == r_min)) || w_snz_hit);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_snz_valid <= 1'b0;
      r_snz_hour  <= '0;
      r_snz_min   <= '0;
    end else if (!i_enable || i_wr_hour || i_wr_min) begin
      r_snz_valid <= 1'b0;
    end else if (i_snooze && r_ringing) begin
      r_snz_valid <= 1'b1;
      r_snz_hour  <= w_snz_target[15:8];
      r_snz_min   <= w_snz_target[7:0];
    end else if (w_at_min && w_snz_hit) begin
      r_snz_valid <= 1'b0;
    end
  end
`else
  logic w_unused_in;
  assign w_unused_in = ^{i_cur_hour, i_cur_min, i_snooze, 7'(SNOOZE_MIN)};
  assign w_hit       = w_at_min && (i_next_hour == r_hour) && (i_next_min == r_min);
`endif

  // Enable-low wins over a same-cycle trigger; a trigger wins over snooze clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hour    <= ALARM_RST_HOUR;
      r_min     <= ALARM_RST_MIN;
      r_ringing <= 1'b0;
    end else begin
      if (i_wr_hour) r_hour <= i_wr_data;
      if (i_wr_min)  r_min  <= i_wr_data;
      if (!i_enable)     r_ringing <= 1'b0;
      else if (w_hit)    r_ringing <= 1'b1;
      else if (i_snooze) r_ringing <= 1'b0;
    end
  end

  assign o_hour    = r_hour;
  assign o_min     = r_min;
  assign o_ringing = r_ringing;
endmodule

// File: rtl/bcd_alarm_clock.sv
// 24-hour BCD timekeeper with NUM_ALARMS alarm slots, 12/24-hour display and 2 Hz buzzer.
// Optional snooze support is compiled in with CLOCK_SNOOZE_EN.
module bcd_alarm_clock #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned NUM_ALARMS = 2,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic              CLK,
  input  logic              RST,
  bcd_alarm_clock_if.slave  bus
);
  import clock_pkg::*;

  localparam int unsigned PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned BEEP = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam int unsigned BW   = (BEEP > 1) ? $clog2(BEEP) : 1;

  logic [PW-1:0] r_presc;
  logic [BW-1:0] r_beep;
  logic [7:0]    r_hour, r_min, r_sec;
  logic          r_tick, r_err, r_b;

  mode_e w_mode;
  logic  w_run, w_tick_now, w_snooze, w_ring_keep;
  logic  w_set_time, w_set_alarm, w_hour_ok, w_min_ok, w_field_ok, w_sel_ok, w_err_now;
  logic [7:0] w_hour_val, w_wr_data, w_next_hour, w_next_min, w_next_sec;
  logic [7:0] w_sel_hour, w_sel_min;
  logic [7:0] w_al_hour [NUM_ALARMS];
  logic [7:0] w_al_min  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] w_al_wr_hour, w_al_wr_min, w_ringing;

  assign w_mode     = mode_e'(bus.MODE);
  assign w_run      = (w_mode == MODE_RUN) || (w_mode == MODE_RUN_ALT);
  assign w_tick_now = w_run && (r_presc == PW'(CLK_HZ - 1));

  assign w_next_sec  = bcd_inc(r_sec, BCD_59);
  assign w_next_min  = (r_sec == BCD_59) ? bcd_inc(r_min, BCD_59) : r_min;
  assign w_next_hour = ((r_sec == BCD_59) && (r_min == BCD_59)) ? bcd_inc(r_hour, BCD_23) : r_hour;

  assign w_hour_ok  = bcd_valid(bus.SW_IN) &&
                      (bus.H24 ? (bus.SW_IN <= BCD_23)
                               : ((bus.SW_IN >= 8'h01) && (bus.SW_IN <= BCD_12)));
  assign w_hour_val = bus.H24 ? bus.SW_IN : hour_to24(bus.SW_IN, bus.PM_IN);
  assign w_min_ok   = bcd_valid(bus.SW_IN) && (bus.SW_IN <= BCD_59);
  assign w_field_ok = bus.FIELD_SEL ? w_min_ok : w_hour_ok;
  assign w_wr_data  = bus.FIELD_SEL ? bus.SW_IN : w_hour_val;
  assign w_sel_ok   = 32'(bus.ALARM_SEL) < NUM_ALARMS;
  assign w_set_time  = bus.LOAD && (w_mode == MODE_SET_TIME);
  assign w_set_alarm = bus.LOAD && (w_mode == MODE_SET_ALARM);
  assign w_err_now   = (w_set_time && !w_field_ok) || (w_set_alarm && !(w_field_ok && w_sel_ok));

  always_comb begin
    w_al_wr_hour = '0;
    w_al_wr_min  = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (w_set_alarm && w_field_ok && (32'(bus.ALARM_SEL) == i)) begin
        w_al_wr_hour[i] = !bus.FIELD_SEL;
        w_al_wr_min[i]  = bus.FIELD_SEL;
      end
    end
  end

`ifdef CLOCK_SNOOZE_EN
  assign w_snooze = bus.SNOOZE;
`else
  logic w_unused_snooze;
  assign w_snooze        = 1'b0;
  assign w_unused_snooze = bus.SNOOZE;
`endif

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
    alarm_slot #(.SNOOZE_MIN(SNOOZE_MIN)) u_slot (
      .i_clk(CLK), .i_rst(RST),
      .i_wr_hour(w_al_wr_hour[g]), .i_wr_min(w_al_wr_min[g]), .i_wr_data(w_wr_data),
      .i_tick(w_tick_now), .i_next_hour(w_next_hour), .i_next_min(w_next_min),
      .i_next_sec(w_next_sec), .i_cur_hour(r_hour), .i_cur_min(r_min),
      .i_enable(bus.A_ENABLE[g]), .i_snooze(w_snooze),
      .o_hour(w_al_hour[g]), .o_min(w_al_min[g]), .o_ringing(w_ringing[g])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_presc <= '0;
      r_hour  <= '0;
      r_min   <= '0;
      r_sec   <= '0;
      r_tick  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_tick <= w_tick_now;
      r_err  <= w_err_now;
      if (!w_run || w_tick_now) r_presc <= '0;
      else                      r_presc <= r_presc + PW'(1);
      if (w_tick_now) begin
        r_sec  <= w_next_sec;
        r_min  <= w_next_min;
        r_hour <= w_next_hour;
      end else if (w_set_time && w_field_ok) begin
        if (bus.FIELD_SEL) begin
          r_min <= bus.SW_IN;
          r_sec <= '0;
        end else begin
          r_hour <= w_hour_val;
        end
      end
    end
  end

  // Look ahead at next-cycle ring state so B drops on the same edge as RINGING.
  assign w_ring_keep = |(w_ringing & bus.A_ENABLE) && !w_snooze;

  always_ff @(posedge CLK) begin
    if (RST || !w_ring_keep) begin
      r_beep <= '0;
      r_b    <= 1'b0;
    end else if (r_beep == BW'(BEEP - 1)) begin
      r_beep <= '0;
      r_b    <= !r_b;
    end else begin
      r_beep <= r_beep + BW'(1);
    end
  end

  assign w_sel_hour = w_sel_ok ? w_al_hour[bus.ALARM_SEL] : 8'h00;
  assign w_sel_min  = w_sel_ok ? w_al_min[bus.ALARM_SEL]  : 8'h00;

  assign bus.HOUR    = bus.H24 ? r_hour : hour_to12(r_hour);
  assign bus.PM      = !bus.H24 && hour_is_pm(r_hour);
  assign bus.MIN     = r_min;
  assign bus.SEC     = r_sec;
  assign bus.AL_HOUR = bus.H24 ? w_sel_hour : hour_to12(w_sel_hour);
  assign bus.AL_MIN  = w_sel_min;
  assign bus.RINGING = w_ringing;
  assign bus.B       = r_b;
  assign bus.TICK    = r_tick;
  assign bus.ERR     = r_err;
endmodule
